// File: rtl/spi_master.sv
// SPI master: one 8-bit full-duplex transfer per accepted start, MSB first.
// Configurable sck divider, idle polarity and sample phase.
module spi_master #(
    parameter int unsigned CLK_DIV = 1,
    parameter bit          CPOL    = 1'b0,
    parameter bit          CPHA    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_2_send,
    input  logic       in,
    output logic [7:0] data_rcv,
    output logic       done,
    output logic       out,
    output logic       sck,
    output logic       cs
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StTransfer, StDone} state_e;

    state_e          state_q;
    logic [DivW-1:0] div_q;
    logic [4:0]      tog_q;
    logic [7:0]      tx_q;
    logic [7:0]      rx_q;
    logic [7:0]      rcv_q;
    logic            cs_q;
    logic            sck_q;
    logic            out_q;
    logic            done_q;

    logic       tick;
    logic       leading;
    logic       last;
    logic [7:0] rx_d;

    // tog_q counts toggles already made, so an even count means the next one is leading.
    always_comb begin
        tick    = (div_q == DivW'(CLK_DIV - 1));
        leading = ~tog_q[0];
        last    = (tog_q == 5'd15);
        rx_d    = {rx_q[6:0], in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            div_q   <= '0;
            tog_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rcv_q   <= '0;
            cs_q    <= 1'b1;
            sck_q   <= CPOL;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        tx_q    <= data_2_send;
                        rx_q    <= '0;
                        div_q   <= '0;
                        tog_q   <= '0;
                        cs_q    <= 1'b0;
                        sck_q   <= CPOL;
                        out_q   <= CPHA ? 1'b0 : data_2_send[7];
                        state_q <= StTransfer;
                    end
                end
                StTransfer: begin
                    if (tick) begin
                        div_q <= '0;
                        sck_q <= ~sck_q;
                        tog_q <= tog_q + 5'd1;
                        if (leading != CPHA) begin
                            rx_q <= rx_d;
                        end else if (CPHA) begin
                            out_q <= tx_q[7];
                            tx_q  <= {tx_q[6:0], 1'b0};
                        end else if (!last) begin
                            out_q <= tx_q[6];
                            tx_q  <= {tx_q[6:0], 1'b0};
                        end
                        if (last) begin
                            // The final toggle is a sample edge only when CPHA=1.
                            rcv_q   <= CPHA ? rx_d : rx_q;
                            done_q  <= 1'b1;
                            cs_q    <= 1'b1;
                            sck_q   <= CPOL;
                            out_q   <= 1'b0;
                            state_q <= StDone;
                        end
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data_rcv = rcv_q;
    assign done     = done_q;
    assign out      = out_q;
    assign sck      = sck_q;
    assign cs       = cs_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: three instances covering mode 0 (div 1 and 3, loopback)
// and mode 3 (div 2, loopback).
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       miso;
    logic       start_r [3];
    logic [7:0] data_r  [3];
    logic [7:0] rcv_w   [3];
    logic       done_w  [3];
    logic       out_w   [3];
    logic       sck_w   [3];
    logic       cs_w    [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start_r[0]), .data_2_send(data_r[0]), .in(miso),
        .data_rcv(rcv_w[0]), .done(done_w[0]), .out(out_w[0]), .sck(sck_w[0]), .cs(cs_w[0])
    );

    spi_master #(.CLK_DIV(3), .CPOL(1'b0), .CPHA(1'b0)) u1 (
        .clk(clk), .rst(rst), .start(start_r[1]), .data_2_send(data_r[1]), .in(out_w[1]),
        .data_rcv(rcv_w[1]), .done(done_w[1]), .out(out_w[1]), .sck(sck_w[1]), .cs(cs_w[1])
    );

    spi_master #(.CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1)) u2 (
        .clk(clk), .rst(rst), .start(start_r[2]), .data_2_send(data_r[2]), .in(out_w[2]),
        .data_rcv(rcv_w[2]), .done(done_w[2]), .out(out_w[2]), .sck(sck_w[2]), .cs(cs_w[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one transfer on instance idx, sampling on falling clk edges. Negedge n follows
    // posedge k+n, where k is the edge that accepts start.
    task automatic xfer(input int idx, input logic [7:0] d, input logic cpol, input int budget,
                        input int poke_at, input int rst_at,
                        output int lat, output int rises, output logic [7:0] obits,
                        output int cslow, output int dones, output int unstable);
        logic prev_sck;
        logic prev_out;
        lat = 0; rises = 0; obits = '0; cslow = 0; dones = 0; unstable = 0;
        @(negedge clk);
        data_r[idx]  = d;
        start_r[idx] = 1'b1;
        @(negedge clk);
        start_r[idx] = 1'b0;
        check($sformatf("u%0d_cs_at_k", idx), cs_w[idx], 0);
        check($sformatf("u%0d_sck_at_k", idx), sck_w[idx], cpol);
        prev_sck = sck_w[idx];
        prev_out = out_w[idx];
        for (int n = 1; n <= budget; n++) begin
            if (cs_w[idx] == 1'b0) cslow++;
            if (n - 1 == poke_at) begin
                start_r[idx] = 1'b1;
                data_r[idx]  = 8'h12;
            end
            if (n - 1 == poke_at + 1) start_r[idx] = 1'b0;
            if (n - 1 == rst_at) rst = 1'b1;
            @(negedge clk);
            if (n - 1 == rst_at) begin
                rst = 1'b0;
                check("rst_mid_cs", cs_w[idx], 1);
                check("rst_mid_sck", sck_w[idx], cpol);
                check("rst_mid_rcv", rcv_w[idx], 8'h00);
                check("rst_mid_done", done_w[idx], 0);
            end
            if (prev_sck == 1'b0 && sck_w[idx] == 1'b1) begin
                rises++;
                obits = {obits[6:0], out_w[idx]};
                if (out_w[idx] !== prev_out) unstable++;
            end
            if (done_w[idx] == 1'b1) begin
                dones++;
                if (lat == 0) lat = n;
            end
            prev_sck = sck_w[idx];
            prev_out = out_w[idx];
        end
    endtask

    int         lat, rises, cslow, dones, unstable;
    logic [7:0] obits;

    initial begin
        rst  = 1'b1;
        miso = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_r[i] = 1'b0;
            data_r[i]  = 8'h00;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_cs", cs_w[0], 1);
        check("rst_sck", sck_w[0], 0);
        check("rst_done", done_w[0], 0);
        check("rst_rcv", rcv_w[0], 8'h00);
        check("rst_cs_u1", cs_w[1], 1);
        check("rst_sck_cpol1", sck_w[2], 1);

        // Mode 0, div 1, MISO held high.
        miso = 1'b1;
        xfer(0, 8'h4D, 1'b0, 20, -10, -10, lat, rises, obits, cslow, dones, unstable);
        check("m0_latency", lat, 16);
        check("m0_rises", rises, 8);
        check("m0_mosi_bits", obits, 8'h4D);
        check("m0_cs_low", cslow, 16);
        check("m0_dones", dones, 1);
        check("m0_mosi_stable", unstable, 0);
        check("m0_rcv", rcv_w[0], 8'hFF);

        // Restart attempt with new data mid-transfer must be ignored.
        miso = 1'b0;
        xfer(0, 8'h4D, 1'b0, 20, 5, -10, lat, rises, obits, cslow, dones, unstable);
        check("restart_mosi_bits", obits, 8'h4D);
        check("restart_dones", dones, 1);
        check("restart_latency", lat, 16);
        check("restart_rcv", rcv_w[0], 8'h00);

        // Loopback, div 3.
        xfer(1, 8'hA5, 1'b0, 52, -10, -10, lat, rises, obits, cslow, dones, unstable);
        check("lb3_rcv", rcv_w[1], 8'hA5);
        check("lb3_latency", lat, 48);
        check("lb3_rises", rises, 8);
        check("lb3_dones", dones, 1);
        check("lb3_cs_low", cslow, 48);

        // Reset at the 4th sck edge (edge k+12), then a clean transfer.
        xfer(1, 8'hA5, 1'b0, 52, -10, 11, lat, rises, obits, cslow, dones, unstable);
        check("rst_mid_no_done", dones, 0);
        xfer(1, 8'h5A, 1'b0, 52, -10, -10, lat, rises, obits, cslow, dones, unstable);
        check("after_rst_rcv", rcv_w[1], 8'h5A);
        check("after_rst_latency", lat, 48);
        check("after_rst_dones", dones, 1);

        // CPOL=1, CPHA=1 loopback, div 2.
        xfer(2, 8'h3C, 1'b1, 36, -10, -10, lat, rises, obits, cslow, dones, unstable);
        check("m3_rcv", rcv_w[2], 8'h3C);
        check("m3_latency", lat, 32);
        check("m3_rises", rises, 8);
        check("m3_mosi_bits", obits, 8'h3C);
        check("m3_mosi_stable", unstable, 0);
        check("m3_sck_idle", sck_w[2], 1);
        check("m3_cs_idle", cs_w[2], 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
